// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit: word-only memory handshake, RMW sub-word stores, load extension
module mem_lsu #(
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] MMIO_BASE = 32'h10000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_DONE} state_t;

    state_t        r_state;
    logic          r_we;
    logic [2:0]    r_f3;
    logic [1:0]    r_lane;
    logic [15:0]   r_wdata;
    logic          r_seen_busy;
    logic [CW-1:0] r_cnt;

    logic          w_bad;
    logic          w_mmio;
    logic          w_sub;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;
    logic [31:0]   w_merge;
    logic [31:0]   w_direct;
    logic          w_done;
    logic          w_expired;

    assign req_ready = (r_state == S_IDLE);

    always_comb begin
        w_bad = 1'b0;
        case (req_funct3)
            3'd0:    w_bad = 1'b0;
            3'd1:    w_bad = req_addr[0];
            3'd2:    w_bad = (req_addr[1:0] != 2'b00);
            3'd4,
            3'd5:    w_bad = req_we;
            default: w_bad = 1'b1;
        endcase
    end

    assign w_mmio = ({req_addr[31:2], 2'b00} == MMIO_BASE);
    assign w_sub  = (req_funct3[1:0] != 2'b10);
    // MMIO sub-word stores bypass RMW and go out zero-extended
    assign w_direct = !w_sub ? req_wdata :
                      (req_funct3[0] ? {16'h0, req_wdata[15:0]} : {24'h0, req_wdata[7:0]});

    assign w_byte    = mem_rdata[{r_lane, 3'b000} +: 8];
    assign w_half    = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign w_done    = r_seen_busy && mem_ready;
    assign w_expired = (r_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        w_load = mem_rdata;
        case (r_f3)
            3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
            3'd1:    w_load = {{16{w_half[15]}}, w_half};
            3'd4:    w_load = {24'h0, w_byte};
            3'd5:    w_load = {16'h0, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    always_comb begin
        w_merge = mem_rdata;
        if (r_f3[0]) begin
            if (r_lane[1]) w_merge[31:16] = r_wdata;
            else           w_merge[15:0]  = r_wdata;
        end else begin
            w_merge[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_f3        <= 3'd0;
            r_lane      <= 2'd0;
            r_wdata     <= 16'h0;
            r_seen_busy <= 1'b0;
            r_cnt       <= '0;
            resp_valid  <= 1'b0;
            resp_rdata  <= 32'h0;
            err         <= 1'b0;
            mem_addr    <= 32'h0;
            mem_wdata   <= 32'h0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
        end else begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            resp_valid <= 1'b0;
            err        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_f3     <= req_funct3;
                        r_lane   <= req_addr[1:0];
                        r_wdata  <= req_wdata[15:0];
                        mem_addr <= {req_addr[31:2], 2'b00};
                        if (w_bad) begin
                            r_state    <= S_DONE;
                            resp_valid <= 1'b1;
                            err        <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else if (!req_we || (w_sub && !w_mmio)) begin
                            r_state  <= S_RD_REQ;
                            mem_read <= 1'b1;
                        end else begin
                            r_state   <= S_WR_REQ;
                            mem_write <= 1'b1;
                            mem_wdata <= w_direct;
                        end
                    end
                end
                S_RD_REQ: begin
                    r_state     <= S_RD_WAIT;
                    r_seen_busy <= 1'b0;
                    r_cnt       <= '0;
                end
                S_RD_WAIT: begin
                    if (!mem_ready) r_seen_busy <= 1'b1;
                    if (w_done) begin
                        if (!r_we) begin
                            r_state    <= S_DONE;
                            resp_valid <= 1'b1;
                            resp_rdata <= w_load;
                        end else begin
                            r_state   <= S_WR_REQ;
                            mem_write <= 1'b1;
                            mem_wdata <= w_merge;
                        end
                    end else if (w_expired) begin
                        r_state    <= S_DONE;
                        resp_valid <= 1'b1;
                        err        <= 1'b1;
                        resp_rdata <= 32'h0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WR_REQ: begin
                    r_state     <= S_WR_WAIT;
                    r_seen_busy <= 1'b0;
                    r_cnt       <= '0;
                end
                S_WR_WAIT: begin
                    if (!mem_ready) r_seen_busy <= 1'b1;
                    if (w_done || w_expired) begin
                        r_state    <= S_DONE;
                        resp_valid <= 1'b1;
                        err        <= !w_done;
                        resp_rdata <= 32'h0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
